taxi_eth_addr_swap: RTL and testbench

TAXI_ETH_ADDR_SWAP -- requirements
Module: taxi_eth_addr_swap

---
 rtl/taxi_eth_addr_swap_if.sv | 26 ++
 rtl/taxi_eth_addr_swap.sv | 203 ++++++++++++++++++++
 tb/tb_taxi_eth_addr_swap.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_eth_addr_swap_if.sv
// AXI4-Stream bundle carrying Ethernet frame words between the RX FIFO, the
// address swapper and the MAC TX path.
interface taxi_axis_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    logic [7:0]        tid;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser, tid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser, tid,
        output tready
    );
endinterface

// File: rtl/taxi_eth_addr_swap.sv
// Swaps the Ethernet destination and source MAC addresses of each frame,
// using a hold word (H) and an output word (O) so the swap spans two beats.
module taxi_eth_addr_swap #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    taxi_axis_if.slave  s_axis,
    taxi_axis_if.master m_axis,
    input  logic        cfg_enable,
    output logic [31:0] stat_swapped_cnt,
    output logic [31:0] stat_short_cnt
);
    localparam int KEEP_W = DATA_W / 8;

    if (DATA_W != 64) begin : g_bad_width
        $error("taxi_eth_addr_swap supports only DATA_W = 64");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] h_data;
    logic [KEEP_W-1:0] h_keep;
    logic              h_last;
    logic [USER_W-1:0] h_user;
    logic [7:0]        h_id;

    logic [DATA_W-1:0] o_data;
    logic [KEEP_W-1:0] o_keep;
    logic              o_last;
    logic [USER_W-1:0] o_user;
    logic [7:0]        o_id;
    logic              o_valid;

    logic        frame_en;
    logic [31:0] swapped_cnt;
    logic [31:0] short_cnt;

    logic o_free;
    logic s_ready;
    logic accept;
    logic swap_ok;

    logic h_load;
    logic h_swap;
    logic o_load;
    logic o_from_h;
    logic o_swap;
    logic flag_load;
    logic inc_swapped;
    logic inc_short;

    // Output word 0: bytes 0-5 take src (word0 bytes 6-7, word1 bytes 0-3),
    // bytes 6-7 take the first two dst bytes.
    function automatic logic [DATA_W-1:0] swap_word0(input logic [DATA_W-1:0] w0,
                                                     input logic [DATA_W-1:0] w1);
        return {w0[15:0], w1[31:0], w0[63:48]};
    endfunction

    // Output word 1: bytes 8-11 take the remaining dst bytes 2-5.
    function automatic logic [DATA_W-1:0] swap_word1(input logic [DATA_W-1:0] w0,
                                                     input logic [DATA_W-1:0] w1);
        return {w1[63:32], w0[47:16]};
    endfunction

    assign o_free  = !o_valid || m_axis.tready;
    assign s_ready = !rst && o_free && (state != DRAIN);
    assign accept  = s_axis.tvalid && s_ready;
    // The swap needs bytes 8-11 present in word 1.
    assign swap_ok = frame_en && (s_axis.tkeep[3:0] == 4'hF);

    always_comb begin
        state_nxt   = state;
        h_load      = 1'b0;
        h_swap      = 1'b0;
        o_load      = 1'b0;
        o_from_h    = 1'b0;
        o_swap      = 1'b0;
        flag_load   = 1'b0;
        inc_swapped = 1'b0;
        inc_short   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_axis.tlast) begin
                        o_load    = 1'b1;
                        inc_short = cfg_enable;
                    end else begin
                        h_load    = 1'b1;
                        flag_load = 1'b1;
                        state_nxt = HDR;
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    o_load   = 1'b1;
                    o_from_h = 1'b1;
                    h_load   = 1'b1;
                    if (swap_ok) begin
                        o_swap      = 1'b1;
                        h_swap      = 1'b1;
                        inc_swapped = 1'b1;
                    end else begin
                        inc_short = frame_en;
                    end
                    state_nxt = s_axis.tlast ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    o_load   = 1'b1;
                    o_from_h = 1'b1;
                    h_load   = 1'b1;
                    if (s_axis.tlast) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (o_free) begin
                    o_load    = 1'b1;
                    o_from_h  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: only these registers see reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_valid     <= 1'b0;
            frame_en    <= 1'b0;
            swapped_cnt <= 32'd0;
            short_cnt   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (o_load) begin
                o_valid <= 1'b1;
            end else if (m_axis.tready) begin
                o_valid <= 1'b0;
            end
            if (flag_load) begin
                frame_en <= cfg_enable;
            end
            if (inc_swapped) begin
                swapped_cnt <= swapped_cnt + 32'd1;
            end
            if (inc_short) begin
                short_cnt <= short_cnt + 32'd1;
            end
        end
    end

    // Hold/output word datapath.
    always_ff @(posedge clk) begin
        if (h_load) begin
            h_data <= h_swap ? swap_word1(h_data, s_axis.tdata) : s_axis.tdata;
            h_keep <= s_axis.tkeep;
            h_last <= s_axis.tlast;
            h_user <= s_axis.tuser;
            h_id   <= s_axis.tid;
        end
        if (o_load) begin
            if (o_from_h) begin
                o_data <= o_swap ? swap_word0(h_data, s_axis.tdata) : h_data;
                o_keep <= h_keep;
                o_last <= h_last;
                o_user <= h_user;
                o_id   <= h_id;
            end else begin
                o_data <= s_axis.tdata;
                o_keep <= s_axis.tkeep;
                o_last <= s_axis.tlast;
                o_user <= s_axis.tuser;
                o_id   <= s_axis.tid;
            end
        end
    end

    assign s_axis.tready = s_ready;

    assign m_axis.tvalid = o_valid;
    assign m_axis.tdata  = o_data;
    assign m_axis.tkeep  = o_keep;
    assign m_axis.tlast  = o_last;
    assign m_axis.tuser  = o_user;
    assign m_axis.tid    = o_id;

    assign stat_swapped_cnt = swapped_cnt;
    assign stat_short_cnt   = short_cnt;
endmodule

// File: tb/tb_taxi_eth_addr_swap.sv
// Bench for taxi_eth_addr_swap: frames are modelled as byte queues, the
// expected output is the byte queue with bytes 0-5 and 6-11 exchanged.
module tb_taxi_eth_addr_swap;
    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [7:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [31:0] stat_swapped_cnt;
    logic [31:0] stat_short_cnt;

    taxi_axis_if #(.DATA_W(64), .USER_W(1)) s_axis ();
    taxi_axis_if #(.DATA_W(64), .USER_W(1)) m_axis ();

    taxi_eth_addr_swap #(.DATA_W(64), .USER_W(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_axis),
        .m_axis           (m_axis),
        .cfg_enable       (cfg_enable),
        .stat_swapped_cnt (stat_swapped_cnt),
        .stat_short_cnt   (stat_short_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    beat_t       exp_q[$];
    beat_t       e;
    beat_t       prev_b;
    bit          prev_stall = 1'b0;
    logic [31:0] mdl_sw = 32'd0;
    logic [31:0] mdl_short = 32'd0;
    bit          rand_ready = 1'b0;
    logic        hold_ready = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink side: tready changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && m_axis.tvalid === 1'b1) begin
            if (prev_stall) begin
                chk("stall_data", m_axis.tdata, prev_b.data);
                chk("stall_last", 64'(m_axis.tlast), 64'(prev_b.last));
            end
            if (m_axis.tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_axis.tvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis.tdata, e.data);
                    chk("out_keep", 64'(m_axis.tkeep), 64'(e.keep));
                    chk("out_last", 64'(m_axis.tlast), 64'(e.last));
                    chk("out_user", 64'(m_axis.tuser), 64'(e.user));
                    chk("out_id", 64'(m_axis.tid), 64'(e.id));
                end
            end
        end
        prev_stall  = !rst && (m_axis.tvalid === 1'b1) && (m_axis.tready !== 1'b1);
        prev_b.data = m_axis.tdata;
        prev_b.last = m_axis.tlast;
    end

    function automatic byte_q_t rand_bytes(input int len);
        byte_q_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic beat_t pack_beat(input byte_q_t q, input int w, input int nb,
                                        input bit user, input logic [7:0] id);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        for (int k = 0; k < 8; k++) begin
            if (w * 8 + k < q.size()) begin
                b.data[k*8 +: 8] = q[w*8 + k];
                b.keep[k] = 1'b1;
            end
        end
        b.last = (w == nb - 1);
        b.user = b.last ? user : 1'b0;
        b.id   = id;
        return b;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input byte_q_t bytes, input bit en, input bit user,
                              input logic [7:0] id, input bit toggle);
        byte_q_t ob;
        beat_t   b;
        int      len;
        int      nb;
        int      n;
        logic [7:0] t;
        len = bytes.size();
        nb  = (len + 7) / 8;
        ob  = bytes;
        if (en) begin
            if (len >= 12) begin
                for (int i = 0; i < 6; i++) begin
                    t = ob[i];
                    ob[i] = ob[i + 6];
                    ob[i + 6] = t;
                end
                mdl_sw = mdl_sw + 32'd1;
            end else begin
                mdl_short = mdl_short + 32'd1;
            end
        end
        for (int w = 0; w < nb; w++) exp_q.push_back(pack_beat(ob, w, nb, user, id));
        cfg_enable = en;
        for (int w = 0; w < nb; w++) begin
            b = pack_beat(bytes, w, nb, user, id);
            s_axis.tdata  = b.data;
            s_axis.tkeep  = b.keep;
            s_axis.tlast  = b.last;
            s_axis.tuser  = b.user;
            s_axis.tid    = b.id;
            s_axis.tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (s_axis.tready !== 1'b1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("accept_timeout", 64'(s_axis.tready), 64'd1);
            @(posedge clk);
            #1;
            if (toggle) cfg_enable = 1'($urandom_range(0, 1));
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_swapped"}, 64'(stat_swapped_cnt), 64'(mdl_sw));
        chk({tag, "_short"}, 64'(stat_short_cnt), 64'(mdl_short));
    endtask

    byte_q_t fr;

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = '0;
        s_axis.tid    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s_axis.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_swapped", 64'(stat_swapped_cnt), 64'd0);
        chk("post_rst_short", 64'(stat_short_cnt), 64'd0);
        chk("idle_tready", 64'(s_axis.tready), 64'd1);

        // 64-byte frame with known addresses, swapped.
        fr = rand_bytes(64);
        for (int i = 0; i < 12; i++) fr[i] = 8'h00;
        fr[0] = 8'h02; fr[5] = 8'h01; fr[6] = 8'h02; fr[11] = 8'h02;
        send_frame(fr, 1'b1, 1'b0, 8'h11, 1'b0);
        wait_drain();
        chk("known_frame_swapped", 64'(stat_swapped_cnt), 64'd1);
        chk_counters("known_frame");

        // Same frame with swapping disabled.
        send_frame(fr, 1'b0, 1'b1, 8'h12, 1'b0);
        wait_drain();
        chk_counters("disabled_frame");

        // Short frames: 10 bytes, then a single-word 4-byte frame.
        send_frame(rand_bytes(10), 1'b1, 1'b0, 8'h13, 1'b0);
        wait_drain();
        chk("short10", 64'(stat_short_cnt), 64'd1);
        send_frame(rand_bytes(4), 1'b1, 1'b1, 8'h14, 1'b0);
        wait_drain();
        chk("short4", 64'(stat_short_cnt), 64'd2);

        // Length boundaries around the 12-byte header and word sizes.
        send_frame(rand_bytes(11), 1'b1, 1'b0, 8'h15, 1'b0);
        send_frame(rand_bytes(12), 1'b1, 1'b1, 8'h16, 1'b0);
        send_frame(rand_bytes(8), 1'b1, 1'b0, 8'h17, 1'b0);
        send_frame(rand_bytes(16), 1'b1, 1'b0, 8'h18, 1'b1);
        send_frame(rand_bytes(9), 1'b0, 1'b0, 8'h19, 1'b0);
        wait_drain();
        chk_counters("boundaries");

        // Back-to-back frames, random sink stalls, enable toggled mid-frame.
        rand_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            send_frame(rand_bytes((f % 3 == 0) ? 64 : int'($urandom_range(1, 80))),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom), 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_counters("random");

        // Reset in the middle of a frame whose output is stalled.
        hold_ready = 1'b0;
        @(posedge clk);
        #1;
        cfg_enable   = 1'b1;
        fr           = rand_bytes(32);
        s_axis.tkeep = 8'hFF;
        s_axis.tlast = 1'b0;
        s_axis.tuser = 1'b0;
        s_axis.tid   = 8'h77;
        for (int w = 0; w < 3; w++) begin
            s_axis.tdata  = pack_beat(fr, w, 4, 1'b0, 8'h77).data;
            s_axis.tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mid_frame_stalled_valid", 64'(m_axis.tvalid), 64'd1);
        chk("mid_frame_stalled_tready", 64'(s_axis.tready), 64'd0);
        rst = 1'b1;
        s_axis.tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        chk("mid_rst_s_tready", 64'(s_axis.tready), 64'd0);
        rst        = 1'b0;
        hold_ready = 1'b1;
        mdl_sw     = 32'd0;
        mdl_short  = 32'd0;
        @(posedge clk);
        #1;
        send_frame(rand_bytes(64), 1'b1, 1'b1, 8'h21, 1'b0);
        wait_drain();
        chk_counters("after_mid_rst");

        // Counter wrap.
        force dut.swapped_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.swapped_cnt;
        @(posedge clk);
        #1;
        chk("preload", 64'(stat_swapped_cnt), 64'hFFFF_FFFF);
        mdl_sw = 32'hFFFF_FFFF;
        send_frame(rand_bytes(24), 1'b1, 1'b0, 8'h22, 1'b0);
        wait_drain();
        chk("wrap", 64'(stat_swapped_cnt), 64'd0);
        chk_counters("wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
